// File: rtl/tuner_pkg.sv
// Shared constants, state encoding and half-period clamp for the reference tone generator.
// The optional TONE_DETUNE_EN build adds a signed offset to the active half-period.
package tuner_pkg;

    localparam int                  PERIOD_W     = 16;
    localparam logic [PERIOD_W-1:0] MIN_HALF     = 16'd2;
    localparam logic [PERIOD_W-1:0] DEFAULT_HALF = 16'd56818;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } tone_state_e;

    function automatic logic [PERIOD_W-1:0] clamp_half(input logic [PERIOD_W-1:0] v);
        return (v < MIN_HALF) ? MIN_HALF : v;
    endfunction

endpackage

// File: rtl/tone_half_calc.sv
// Combinational effective half-period: active value, optionally offset by a signed detune
// (macro TONE_DETUNE_EN) and saturated to [MIN_HALF, 2^PERIOD_W-1].
module tone_half_calc
    import tuner_pkg::*;
(
    input  logic [PERIOD_W-1:0] active,
    input  logic [PERIOD_W-1:0] detune,
    output logic [PERIOD_W-1:0] half
);

`ifdef TONE_DETUNE_EN
    // Two guard bits so that a large active plus a large positive detune cannot wrap.
    localparam int SW = PERIOD_W + 2;
    localparam logic signed [SW-1:0] LO = $signed({2'b00, MIN_HALF});
    localparam logic signed [SW-1:0] HI = $signed({2'b00, {PERIOD_W{1'b1}}});

    logic signed [SW-1:0] sum;

    always_comb begin
        sum = $signed({2'b00, active}) + $signed({{2{detune[PERIOD_W-1]}}, detune});
        if (sum < LO) begin
            half = MIN_HALF;
        end else if (sum > HI) begin
            half = {PERIOD_W{1'b1}};
        end else begin
            half = sum[PERIOD_W-1:0];
        end
    end
`else
    logic unused_detune;

    assign unused_detune = ^detune;
    assign half          = clamp_half(active);
`endif

endmodule

// File: rtl/reference_tone_gen.sv
// 50%-duty square-wave reference tone with a valid/ready loaded half-period, applied only at
// period boundaries. Build macro TONE_DETUNE_EN enables the signed detune offset.
module reference_tone_gen
    import tuner_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                enable,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [PERIOD_W-1:0] load_half,
    input  logic [PERIOD_W-1:0] detune,
    output logic                tone_out,
    output logic                cycle_pulse,
    output logic                busy,
    output logic [1:0]          state_dbg
);

    // Handshake: a request transfers on a rising clk edge where load_valid && load_ready;
    // load_ready is low only while one request is already pending (state PEND).

    tone_state_e         state_q, state_d;
    logic                tone_q, tone_d;
    logic                pulse_q, pulse_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] active_q, active_d;
    logic [PERIOD_W-1:0] pend_half_q, pend_half_d;
    logic [PERIOD_W-1:0] half_q, half_d;

    logic                accept;
    logic [PERIOD_W-1:0] load_clamped;
    logic [PERIOD_W-1:0] next_active;
    logic [PERIOD_W-1:0] next_h;

    assign load_ready   = (state_q != PEND);
    assign accept       = load_valid && load_ready;
    assign load_clamped = clamp_half(load_half);

    // Value that becomes active if a period starts on this edge.
    always_comb begin
        next_active = active_q;
        if (state_q == IDLE) begin
            if (accept) next_active = load_clamped;
        end else if (state_q == PEND) begin
            next_active = pend_half_q;
        end
    end

    tone_half_calc u_half_calc (
        .active (next_active),
        .detune (detune),
        .half   (next_h)
    );

    always_comb begin
        state_d     = state_q;
        tone_d      = tone_q;
        pulse_d     = 1'b0;
        cnt_d       = cnt_q;
        active_d    = active_q;
        pend_half_d = pend_half_q;
        half_d      = half_q;

        case (state_q)
            IDLE: begin
                tone_d   = 1'b0;
                active_d = next_active;
                if (enable) begin
                    state_d = RUN;
                    tone_d  = 1'b1;
                    pulse_d = 1'b1;
                    half_d  = next_h;
                    cnt_d   = next_h - PERIOD_W'(1);
                end
            end
            RUN, PEND: begin
                if (accept) begin
                    pend_half_d = load_clamped;
                    state_d     = PEND;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - PERIOD_W'(1);
                end else if (tone_q) begin
                    tone_d = 1'b0;
                    cnt_d  = half_q - PERIOD_W'(1);
                end else begin
                    // Period boundary: commit any pending pitch, then restart or stop.
                    active_d = next_active;
                    if (!enable) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                        if (accept) active_d = load_clamped;
                    end else begin
                        state_d = accept ? PEND : RUN;
                        tone_d  = 1'b1;
                        pulse_d = 1'b1;
                        half_d  = next_h;
                        cnt_d   = next_h - PERIOD_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tone_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            tone_q      <= 1'b0;
            pulse_q     <= 1'b0;
            cnt_q       <= '0;
            active_q    <= DEFAULT_HALF;
            pend_half_q <= DEFAULT_HALF;
            half_q      <= DEFAULT_HALF;
        end else begin
            state_q     <= state_d;
            tone_q      <= tone_d;
            pulse_q     <= pulse_d;
            cnt_q       <= cnt_d;
            active_q    <= active_d;
            pend_half_q <= pend_half_d;
            half_q      <= half_d;
        end
    end

    assign tone_out    = tone_q;
    assign cycle_pulse = pulse_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_reference_tone_gen.sv
// Directed bench for reference_tone_gen: phase lengths, handshake timing, stop and reset;
// detune cases are added when TONE_DETUNE_EN is defined.
module tb_reference_tone_gen;
    import tuner_pkg::*;

    logic                clk;
    logic                resetn;
    logic                enable;
    logic                load_valid;
    logic                load_ready;
    logic [PERIOD_W-1:0] load_half;
    logic [PERIOD_W-1:0] detune;
    logic                tone_out;
    logic                cycle_pulse;
    logic                busy;
    logic [1:0]          state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    reference_tone_gen dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_half   (load_half),
        .detune      (detune),
        .tone_out    (tone_out),
        .cycle_pulse (cycle_pulse),
        .busy        (busy),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts consecutive negedge samples at lvl, ending on the first sample that differs.
    task automatic count_level(input logic lvl, input int limit, output int n);
        n = 0;
        while (tone_out === lvl && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Starting on a cycle_pulse sample, measures one full period.
    task automatic measure(input string tag, input int exp_hi, input int exp_lo);
        int hi;
        int lo;
        check({tag, " pulse"}, 32'(cycle_pulse), 32'd1);
        count_level(1'b1, 1000, hi);
        count_level(1'b0, 1000, lo);
        check({tag, " high"}, hi, exp_hi);
        check({tag, " low"}, lo, exp_lo);
    endtask

    task automatic load_one(input logic [PERIOD_W-1:0] v);
        load_valid = 1'b1;
        load_half  = v;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        int n;
        resetn     = 1'b0;
        enable     = 1'b0;
        load_valid = 1'b0;
        load_half  = '0;
`ifdef TONE_DETUNE_EN
        detune     = '0;
`else
        detune     = 16'hFFF6;
`endif
        repeat (3) @(negedge clk);
        check("rst tone", 32'(tone_out), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("rst pulse", 32'(cycle_pulse), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst ready", 32'(load_ready), 32'd1);
        check("rst state", 32'(state_dbg), 32'(IDLE));

        // T1: default pitch
        enable = 1'b1;
        @(negedge clk);
        check("t1 pulse", 32'(cycle_pulse), 32'd1);
        check("t1 busy", 32'(busy), 32'd1);
`ifdef TONE_DETUNE_EN
        repeat (1000) @(negedge clk);
        check("t1 still high", 32'(tone_out), 32'd1);
`else
        count_level(1'b1, 60000, n);
        check("t1 high len", n, 56818);
        check("t1 low pulse", 32'(cycle_pulse), 32'd0);
`endif
        resetn = 1'b0;
        enable = 1'b0;
        #1;
        check("t1 async rst", 32'(tone_out), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // T2: load 5 in IDLE, then a request of 1 clamps to MIN_HALF
        load_one(16'd5);
        check("t2 idle state", 32'(state_dbg), 32'(IDLE));
        enable = 1'b1;
        @(negedge clk);
        measure("t2 h5", 5, 5);
        load_one(16'd1);
        check("t2 ready low", 32'(load_ready), 32'd0);
        check("t2 pend", 32'(state_dbg), 32'(PEND));
        count_level(1'b1, 1000, n);
        check("t2 rest high", n, 4);
        count_level(1'b0, 1000, n);
        check("t2 rest low", n, 5);
        check("t2 ready back", 32'(load_ready), 32'd1);
        measure("t2 h2", 2, 2);

        // T3: move to H=5, then load 8 mid-high-phase
        load_one(16'd5);
        count_level(1'b1, 1000, n);
        check("t3 h2 rest high", n, 1);
        count_level(1'b0, 1000, n);
        check("t3 h2 low", n, 2);
        check("t3 pulse", 32'(cycle_pulse), 32'd1);
        repeat (2) @(negedge clk);
        load_one(16'd8);
        check("t3 ready low", 32'(load_ready), 32'd0);
        count_level(1'b1, 1000, n);
        check("t3 rest high", n, 2);
        count_level(1'b0, 1000, n);
        check("t3 low", n, 5);
        check("t3 ready back", 32'(load_ready), 32'd1);
        measure("t3 h8", 8, 8);

        // T4: request transfers on the boundary edge itself
        repeat (15) @(negedge clk);
        load_one(16'd3);
        check("t4 boundary pulse", 32'(cycle_pulse), 32'd1);
        check("t4 ready low", 32'(load_ready), 32'd0);
        measure("t4 old h", 8, 8);
        check("t4 ready back", 32'(load_ready), 32'd1);
        check("t4 run", 32'(state_dbg), 32'(RUN));
        measure("t4 h3", 3, 3);

        // T5: stop mid-period at H=5
        load_one(16'd5);
        count_level(1'b1, 1000, n);
        check("t5 h3 rest high", n, 2);
        count_level(1'b0, 1000, n);
        check("t5 h3 low", n, 3);
        check("t5 pulse", 32'(cycle_pulse), 32'd1);
        repeat (2) @(negedge clk);
        enable = 1'b0;
        count_level(1'b1, 1000, n);
        check("t5 rest high", n, 3);
        repeat (4) @(negedge clk);
        check("t5 busy last low", 32'(busy), 32'd1);
        @(negedge clk);
        check("t5 busy off", 32'(busy), 32'd0);
        check("t5 idle", 32'(state_dbg), 32'(IDLE));
        check("t5 tone low", 32'(tone_out), 32'd0);
        repeat (3) @(negedge clk);
        check("t5 no pulse", 32'(cycle_pulse), 32'd0);

        // T5b: reset mid-high with a request pending
        enable = 1'b1;
        @(negedge clk);
        check("t5b start", 32'(tone_out), 32'd1);
        load_one(16'd9);
        check("t5b pend", 32'(load_ready), 32'd0);
        resetn = 1'b0;
        enable = 1'b0;
        #1;
        check("t5b tone", 32'(tone_out), 32'd0);
        check("t5b busy", 32'(busy), 32'd0);
        check("t5b ready", 32'(load_ready), 32'd1);
        check("t5b state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("t5b idle tone", 32'(tone_out), 32'd0);

`ifdef TONE_DETUNE_EN
        // T6: detune offsets and saturation
        detune = 16'hFFFE;
        load_one(16'd5);
        enable = 1'b1;
        @(negedge clk);
        measure("t6 m2", 3, 3);
        detune = 16'hFFF6;
        measure("t6 mid change", 3, 3);
        measure("t6 floor", 2, 2);
        detune = 16'd100;
        load_one(16'd65530);
        count_level(1'b1, 1000, n);
        check("t6 rest high", n, 1);
        count_level(1'b0, 1000, n);
        check("t6 rest low", n, 2);
        check("t6 pulse", 32'(cycle_pulse), 32'd1);
        count_level(1'b1, 70000, n);
        check("t6 ceiling", n, 65535);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
